nn_img_loader: RTL and testbench

- Upstream feeder for the digit-classifier core (nn).
- Accepts a raster-order grayscale pixel stream from the 280x280 drawing canvas and downsamples it 10x10 -> 1 to the 28x28 binarized 784-bit image the core consumes.
- Pulses the core's start, waits for its response, and latches the 5-bit prediction for the display/HUD logic.

---
 rtl/nn_pkg.sv | 17 +
 rtl/nn_blk_acc.sv | 41 ++++
 rtl/nn_img_loader.sv | 203 ++++++++++++++++++++
 tb/tb_nn_img_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants and FSM state type for the nn image loader.
package nn_pkg;

   localparam int unsigned IMG_DIM  = 28;
   localparam int unsigned IMG_BITS = IMG_DIM * IMG_DIM;
   localparam int unsigned PRED_W   = 5;
   localparam logic [PRED_W-1:0] PRED_INVALID = 5'd31;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_START,
      ST_WAIT,
      ST_DONE
   } nn_ld_state_t;

endpackage

// File: rtl/nn_blk_acc.sv
// Per-column ink accumulators for one block row; emits the majority bit
// and its write strobe on the last pixel of each block.
module nn_blk_acc
   import nn_pkg::*;
#(
   parameter int unsigned SCALE      = 10,
   parameter int unsigned MAJ_THRESH = 50
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       inc,
   input  logic                       last,
   input  logic                       ink,
   input  logic [$clog2(IMG_DIM)-1:0] idx,
   output logic                       blk_bit_c,
   output logic                       wr_c
);

   localparam int unsigned ACC_W = $clog2(SCALE * SCALE + 1);

   logic [ACC_W-1:0] acc [IMG_DIM];
   logic [ACC_W-1:0] sum_c;

   // A clear coincides with the first pixel of a frame, so it sees an empty accumulator.
   assign sum_c     = (clr ? '0 : acc[idx]) + ACC_W'(ink);
   assign blk_bit_c = (sum_c >= ACC_W'(MAJ_THRESH));
   assign wr_c      = inc & last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(IMG_DIM); i++) acc[i] <= '0;
      end else begin
         if (clr) begin
            for (int i = 0; i < int'(IMG_DIM); i++) acc[i] <= '0;
         end
         if (inc) acc[idx] <= last ? '0 : sum_c;
      end
   end

endmodule

// File: rtl/nn_img_loader.sv
// Downsamples a raster canvas stream to a 28x28 binary image, runs the nn core
// and latches its prediction. NN_LOADER_TIMEOUT_EN adds a watchdog on the core.
module nn_img_loader
   import nn_pkg::*;
#(
   parameter int unsigned SCALE      = 10,
   parameter logic [7:0]  PIX_THRESH = 8'd128,
   parameter int unsigned MAJ_THRESH = 50
`ifdef NN_LOADER_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYC = 1_000_000
`endif
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pix_valid,
   output logic                pix_ready,
   input  logic                pix_sof,
   input  logic [7:0]          pix_data,
   output logic [IMG_BITS-1:0] nn_data,
   output logic                nn_start,
   input  logic                nn_resp,
   input  logic [PRED_W-1:0]   nn_pred,
   output logic [PRED_W-1:0]   pred,
   output logic                pred_valid,
   output logic                busy,
   output logic                timeout
);

   localparam int unsigned SC_W  = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam int unsigned BLK_W = $clog2(IMG_DIM);
   localparam int unsigned BIT_W = $clog2(IMG_BITS);

   nn_ld_state_t      state, state_nxt;
   logic [SC_W-1:0]   cx, cy, cx_nxt, cy_nxt, pcx, pcy;
   logic [BLK_W-1:0]  bx, by, bx_nxt, by_nxt, pbx, pby;
   logic [PRED_W-1:0] pred_nxt;
   logic              pred_valid_nxt, pix_ready_nxt, busy_nxt, nn_start_nxt;
   logic              wait_arm, wait_arm_nxt;
   logic              xfer, take, ink, last_col, last_row, blk_last, pix_final;
   logic              acc_clr, acc_wr_c, blk_bit_c;
   logic [BIT_W-1:0]  bit_idx;

   // Pixel position of the current transfer; a sof pixel is always (0,0).
   assign xfer      = pix_valid & pix_ready;
   assign take      = xfer & ((state == ST_FILL) |
                              (pix_sof & ((state == ST_IDLE) | (state == ST_DONE))));
   assign ink       = (pix_data >= PIX_THRESH);
   assign pcx       = pix_sof ? '0 : cx;
   assign pcy       = pix_sof ? '0 : cy;
   assign pbx       = pix_sof ? '0 : bx;
   assign pby       = pix_sof ? '0 : by;
   assign last_col  = (pcx == SC_W'(SCALE - 1));
   assign last_row  = (pcy == SC_W'(SCALE - 1));
   assign blk_last  = last_col & last_row;
   assign pix_final = blk_last & (pbx == BLK_W'(IMG_DIM - 1)) & (pby == BLK_W'(IMG_DIM - 1));
   assign acc_clr   = take & pix_sof;
   assign bit_idx   = BIT_W'(IMG_BITS - 1) - (BIT_W'(pby) * BIT_W'(IMG_DIM) + BIT_W'(pbx));

   nn_blk_acc #(
      .SCALE      (SCALE),
      .MAJ_THRESH (MAJ_THRESH)
   ) u_blk_acc (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (acc_clr),
      .inc       (take),
      .last      (blk_last),
      .ink       (ink),
      .idx       (pbx),
      .blk_bit_c (blk_bit_c),
      .wr_c      (acc_wr_c)
   );

`ifdef NN_LOADER_TIMEOUT_EN
   localparam int unsigned WD_W = 20;
   logic [WD_W-1:0] wdog, wdog_nxt;
   logic            timeout_nxt;
`endif

   // Next-state, counter advance and registered-output decode.
   always_comb begin
      state_nxt      = state;
      cx_nxt         = cx;
      cy_nxt         = cy;
      bx_nxt         = bx;
      by_nxt         = by;
      pred_nxt       = pred;
      pred_valid_nxt = pred_valid;
      wait_arm_nxt   = 1'b0;
`ifdef NN_LOADER_TIMEOUT_EN
      wdog_nxt       = '0;
      timeout_nxt    = timeout;
`endif

      case (state)
         ST_IDLE, ST_DONE: begin
            if (take) begin
               state_nxt      = ST_FILL;
               pred_valid_nxt = 1'b0;
            end
         end
         ST_FILL: begin
            if (take && pix_final) state_nxt = ST_START;
         end
         ST_START: state_nxt = ST_WAIT;
         ST_WAIT: begin
            // First WAIT cycle is skipped: nn_resp may still hold the previous run.
            wait_arm_nxt = 1'b1;
`ifdef NN_LOADER_TIMEOUT_EN
            wdog_nxt = wdog + WD_W'(1);
`endif
            if (wait_arm && nn_resp) begin
               pred_nxt       = nn_pred;
               pred_valid_nxt = 1'b1;
               state_nxt      = ST_DONE;
            end
`ifdef NN_LOADER_TIMEOUT_EN
            else if (wdog == WD_W'(TIMEOUT_CYC - 1)) begin
               timeout_nxt    = 1'b1;
               pred_nxt       = PRED_INVALID;
               pred_valid_nxt = 1'b1;
               state_nxt      = ST_DONE;
            end
`endif
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (take) begin
         cx_nxt = pcx + SC_W'(1);
         cy_nxt = pcy;
         bx_nxt = pbx;
         by_nxt = pby;
         if (last_col) begin
            cx_nxt = '0;
            if (pbx == BLK_W'(IMG_DIM - 1)) begin
               bx_nxt = '0;
               if (last_row) begin
                  cy_nxt = '0;
                  by_nxt = (pby == BLK_W'(IMG_DIM - 1)) ? '0 : pby + BLK_W'(1);
               end else begin
                  cy_nxt = pcy + SC_W'(1);
               end
            end else begin
               bx_nxt = pbx + BLK_W'(1);
            end
         end
      end

      pix_ready_nxt = state_nxt inside {ST_IDLE, ST_FILL, ST_DONE};
      busy_nxt      = !(state_nxt inside {ST_IDLE, ST_DONE});
      nn_start_nxt  = (state_nxt == ST_START);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cx         <= '0;
         cy         <= '0;
         bx         <= '0;
         by         <= '0;
         pred       <= '0;
         pred_valid <= 1'b0;
         pix_ready  <= 1'b0;
         busy       <= 1'b0;
         nn_start   <= 1'b0;
         wait_arm   <= 1'b0;
      end else begin
         state      <= state_nxt;
         cx         <= cx_nxt;
         cy         <= cy_nxt;
         bx         <= bx_nxt;
         by         <= by_nxt;
         pred       <= pred_nxt;
         pred_valid <= pred_valid_nxt;
         pix_ready  <= pix_ready_nxt;
         busy       <= busy_nxt;
         nn_start   <= nn_start_nxt;
         wait_arm   <= wait_arm_nxt;
      end
   end

   // Image bits are written as each block completes and otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        nn_data <= '0;
      else if (acc_wr_c) nn_data[bit_idx] <= blk_bit_c;
   end

`ifdef NN_LOADER_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog    <= '0;
         timeout <= 1'b0;
      end else begin
         wdog    <= wdog_nxt;
         timeout <= timeout_nxt;
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_nn_img_loader.sv
// Self-checking bench for nn_img_loader on a reduced 3x3-per-bit canvas (84x84).
module tb_nn_img_loader;
   import nn_pkg::*;

   localparam int SCALE = 3;
   localparam int MAJ   = 5;
   localparam int SIDE  = IMG_DIM * SCALE;
   localparam int NPIX  = SIDE * SIDE;
   localparam int BOUND = 2000;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                pix_valid, pix_ready, pix_sof;
   logic [7:0]          pix_data;
   logic [IMG_BITS-1:0] nn_data;
   logic                nn_start, nn_resp;
   logic [PRED_W-1:0]   nn_pred, pred;
   logic                pred_valid, busy, timeout;

   int n_tests = 0;
   int n_fail  = 0;
   int starts  = 0;

   logic [7:0] frame [NPIX];

   nn_img_loader #(
      .SCALE      (SCALE),
      .PIX_THRESH (8'd128),
      .MAJ_THRESH (MAJ)
`ifdef NN_LOADER_TIMEOUT_EN
      , .TIMEOUT_CYC (100)
`endif
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_sof    (pix_sof),
      .pix_data   (pix_data),
      .nn_data    (nn_data),
      .nn_start   (nn_start),
      .nn_resp    (nn_resp),
      .nn_pred    (nn_pred),
      .pred       (pred),
      .pred_valid (pred_valid),
      .busy       (busy),
      .timeout    (timeout)
   );

   always #10 clk = ~clk;

   always @(negedge clk) if (nn_start) starts++;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [IMG_BITS-1:0] act,
                        input logic [IMG_BITS-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Reference image: count inked canvas pixels of each block, majority vote.
   function automatic logic [IMG_BITS-1:0] model();
      logic [IMG_BITS-1:0] img;
      int ink;
      img = '0;
      for (int r = 0; r < IMG_DIM; r++) begin
         for (int c = 0; c < IMG_DIM; c++) begin
            ink = 0;
            for (int y = 0; y < SCALE; y++)
               for (int x = 0; x < SCALE; x++)
                  if (frame[(r * SCALE + y) * SIDE + c * SCALE + x] >= 8'd128) ink++;
            img[IMG_BITS - 1 - (r * IMG_DIM + c)] = (ink >= MAJ);
         end
      end
      return img;
   endfunction

   task automatic fill_const(input logic [7:0] v);
      for (int i = 0; i < NPIX; i++) frame[i] = v;
   endtask

   task automatic fill_block(input int n);
      fill_const(8'd0);
      for (int j = 0; j < n; j++) frame[(j / SCALE) * SIDE + (j % SCALE)] = 8'd200;
   endtask

   task automatic fill_rand();
      logic [7:0] pick [4];
      pick[0] = 8'd0; pick[1] = 8'd127; pick[2] = 8'd128; pick[3] = 8'd255;
      for (int i = 0; i < NPIX; i++) begin
         if ($urandom_range(1) == 0) frame[i] = pick[$urandom_range(3)];
         else                        frame[i] = 8'($urandom);
      end
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #2;
      check({tag, " rst nn_data"}, nn_data, '0);
      check({tag, " rst flags"}, {pix_ready, nn_start, pred_valid, busy, timeout}, '0);
      check({tag, " rst pred"}, pred, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Offer one pixel and hold it until it is accepted (bounded).
   task automatic push(input logic [7:0] d, input logic s);
      int n;
      n = 0;
      pix_valid = 1'b1;
      pix_data  = d;
      pix_sof   = s;
      @(negedge clk);
      while (!pix_ready && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      if (!pix_ready) check("push ready", pix_ready, 1'b1);
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
   endtask

   task automatic send(input int n, input int gap_pct);
      for (int i = 0; i < n; i++) begin
         if (gap_pct != 0 && int'($urandom_range(99)) < gap_pct) begin
            pix_data = 8'($urandom);
            pix_sof  = 1'($urandom);
            @(posedge clk);
            #1;
         end
         push(frame[i], i == 0);
      end
   endtask

   // Called right after the final pixel transfer: checks the start pulse,
   // stubs the core response and checks the latched result.
   task automatic run_core(input string tag, input logic [IMG_BITS-1:0] exp_img,
                           input int delay, input logic [PRED_W-1:0] predv,
                           input bit stale, input bit bp);
      int n, s0;
      s0 = starts;
      @(negedge clk);
      check({tag, " start"}, nn_start, 1'b1);
      check({tag, " ready_lo"}, pix_ready, 1'b0);
      check({tag, " pv_clr"}, pred_valid, 1'b0);
      check({tag, " img"}, nn_data, exp_img);
      if (stale) begin
         nn_resp = 1'b1;
         nn_pred = predv;
      end
      if (bp) begin
         pix_valid = 1'b1;
         pix_sof   = 1'b1;
         pix_data  = 8'hff;
      end
      @(negedge clk);
      check({tag, " start_lo"}, nn_start, 1'b0);
      check({tag, " busy"}, busy, 1'b1);
      if (stale) begin
         @(negedge clk);
         check({tag, " stale_ign"}, pred_valid, 1'b0);
      end
      if (bp) begin
         for (int i = 0; i < 6; i++) begin
            check({tag, " bp_ready"}, pix_ready, 1'b0);
            @(negedge clk);
         end
         pix_valid = 1'b0;
         pix_sof   = 1'b0;
      end
      if (!stale) begin
         repeat (delay) @(negedge clk);
         nn_resp = 1'b1;
         nn_pred = predv;
      end
      n = 0;
      while (!pred_valid && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      if (stale) check({tag, " stale_lat"}, n, 1);
      check({tag, " pred_valid"}, pred_valid, 1'b1);
      check({tag, " pred"}, pred, predv);
      check({tag, " idle"}, {busy, pix_ready}, 2'b01);
      nn_resp = 1'b0;
      check({tag, " one_start"}, starts, s0 + 1);
      if (bp) begin
         repeat (2) @(negedge clk);
         check({tag, " bp_kept"}, {pred_valid, busy}, 2'b10);
      end
      check({tag, " img_hold"}, nn_data, exp_img);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int                kind;     // 0: uniform value, 1: inked pixels in block (0,0)
      int                arg;
      logic [PRED_W-1:0] predv;
      int                delay;
      int                exp_pop;
      logic              exp_msb;
   } vec_t;

   vec_t vt [5];

   initial begin
      logic [IMG_BITS-1:0] exp_img;
      int n;

      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      pix_data  = 8'd0;
      nn_resp   = 1'b0;
      nn_pred   = '0;

      vt[0] = '{kind: 0, arg: 0,       predv: 5'd7,  delay: 20, exp_pop: 0,        exp_msb: 1'b0};
      vt[1] = '{kind: 1, arg: MAJ,     predv: 5'd3,  delay: 5,  exp_pop: 1,        exp_msb: 1'b1};
      vt[2] = '{kind: 1, arg: MAJ - 1, predv: 5'd12, delay: 3,  exp_pop: 0,        exp_msb: 1'b0};
      vt[3] = '{kind: 0, arg: 127,     predv: 5'd30, delay: 1,  exp_pop: 0,        exp_msb: 1'b0};
      vt[4] = '{kind: 0, arg: 128,     predv: 5'd0,  delay: 2,  exp_pop: IMG_BITS, exp_msb: 1'b1};

      do_reset("por");

      for (int k = 0; k < 5; k++) begin
         if (vt[k].kind == 0) fill_const(8'(vt[k].arg));
         else                 fill_block(vt[k].arg);
         exp_img = model();
         send(NPIX, 0);
         run_core($sformatf("v%0d", k), exp_img, vt[k].delay, vt[k].predv, 1'b0, 1'b0);
         check($sformatf("v%0d pop", k), $countones(nn_data), vt[k].exp_pop);
         check($sformatf("v%0d msb", k), nn_data[IMG_BITS-1], vt[k].exp_msb);
         check($sformatf("v%0d timeout", k), timeout, 1'b0);
      end

      // Reset half-way through a frame, then a full random frame with back-pressure in WAIT.
      fill_rand();
      send(NPIX / 2, 0);
      do_reset("mid");
      send(NPIX, 0);
      exp_img = model();
      run_core("rnd", exp_img, 4, 5'd9, 1'b0, 1'b1);

      // Same image with random valid gaps; response already high when WAIT begins.
      send(NPIX, 15);
      run_core("gap", exp_img, 0, 5'd21, 1'b1, 1'b0);

      // sof at pixel 500 restarts the frame; then reset while waiting on the core.
      fill_rand();
      send(500, 0);
      fill_rand();
      exp_img = model();
      send(NPIX, 0);
      @(negedge clk);
      check("restart start", nn_start, 1'b1);
      check("restart img", nn_data, exp_img);
      @(negedge clk);
      check("restart busy", busy, 1'b1);
      do_reset("wait");

`ifdef NN_LOADER_TIMEOUT_EN
      fill_const(8'd0);
      send(NPIX, 0);
      @(negedge clk);
      check("to start", nn_start, 1'b1);
      n = 0;
      while (!pred_valid && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("to flag", timeout, 1'b1);
      check("to pred", pred, 5'd31);
      check("to pred_valid", pred_valid, 1'b1);
      check("to latency", (n >= 100 && n <= 102), 1'b1);
`else
      n = 0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
